// File: rtl/kalman_fp_pkg.sv
// Shared definitions for the Kalman floating-point matrix sequencers
// (add / sub / mul siblings all import this package).
package kalman_fp_pkg;

    localparam int FP_DW = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } mat_sub_state_e;

endpackage : kalman_fp_pkg

// File: rtl/mat_sub_seq.sv
// Element-wise matrix subtraction sequencer: streams A/B element pairs into
// fp_suber and gathers the in-order results into mat_c.
module mat_sub_seq
    import kalman_fp_pkg::*;
#(
    parameter int DIM  = 4,
    parameter int DW   = FP_DW,
    parameter int IDXW = $clog2(DIM*DIM+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM*DIM*DW-1:0] mat_a,
    input  logic [DIM*DIM*DW-1:0] mat_b,
    output logic                  busy,
    output logic                  done,
    output logic [DIM*DIM*DW-1:0] mat_c,
    output logic                  err_unexp,
    output logic [DW-1:0]         sub_a,
    output logic [DW-1:0]         sub_b,
    output logic                  sub_valid,
    input  logic                  sub_finish,
    input  logic [DW-1:0]         sub_result
);

    localparam int NE = DIM*DIM;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NE-1);
    localparam logic [IDXW-1:0] FULL_IDX = IDXW'(NE);

    mat_sub_state_e state, state_nxt;

    logic [IDXW-1:0] iss_idx, col_idx;
    logic [IDXW-1:0] iss_nxt;
    logic [EW-1:0]   iss_sel, col_sel;
    logic [DW-1:0]   a_mem [NE];
    logic [DW-1:0]   b_mem [NE];
    logic            accept, collect, collect_last, issue_last;

    assign accept  = (state == IDLE) && start;
    assign iss_nxt = iss_idx + 1'b1;
    assign iss_sel = iss_nxt[EW-1:0];
    assign col_sel = col_idx[EW-1:0];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        collect      = sub_finish && ((state == ISSUE) || (state == DRAIN))
                       && (col_idx != FULL_IDX);
        collect_last = collect && (col_idx == LAST_IDX);
        issue_last   = (state == ISSUE) && (iss_idx == LAST_IDX);
        state_nxt    = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE: begin
                // With a zero-latency subtractor the final collect lands while still issuing.
                if (collect_last)    state_nxt = DONE;
                else if (issue_last) state_nxt = DRAIN;
            end
            DRAIN:   if (collect_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: operand stores carry no reset; they are always loaded on start before any read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NE; i++) begin
                a_mem[i] <= mat_a[i*DW +: DW];
                b_mem[i] <= mat_b[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_idx   <= '0;
            col_idx   <= '0;
            sub_a     <= '0;
            sub_b     <= '0;
            sub_valid <= 1'b0;
            mat_c     <= '0;
            err_unexp <= 1'b0;
        end else begin
            // Element 0 is taken straight from the ports so it is on the bus in the first ISSUE cycle.
            if (accept) begin
                iss_idx   <= '0;
                col_idx   <= '0;
                sub_valid <= 1'b1;
                sub_a     <= mat_a[DW-1:0];
                sub_b     <= mat_b[DW-1:0];
            end else if (state == ISSUE) begin
                iss_idx <= iss_nxt;
                if (issue_last) begin
                    sub_valid <= 1'b0;
                end else begin
                    sub_a <= a_mem[iss_sel];
                    sub_b <= b_mem[iss_sel];
                end
            end

            if (collect) begin
                mat_c[int'(col_sel)*DW +: DW] <= sub_result;
                col_idx <= col_idx + 1'b1;
            end

            if (sub_finish && !collect) err_unexp <= 1'b1;
        end
    end

endmodule : mat_sub_seq

// File: tb/tb_mat_sub_seq.sv
// Scoreboard bench for mat_sub_seq (DIM=4 and DIM=2) with a latency-L
// behavioural subtractor standing in for fp_suber.
module tb_mat_sub_seq;
    import kalman_fp_pkg::*;

    localparam int L   = 3;
    localparam int DW  = 64;
    localparam int NE4 = 16;
    localparam int NE2 = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DIM=4 instance
    logic              start4, busy4, done4, err4, sv4, sf4;
    logic [NE4*DW-1:0] mat_a4, mat_b4, mat_c4;
    logic [DW-1:0]     sa4, sb4, sr4;
    // DIM=2 instance
    logic              start2, busy2, done2, err2, sv2, sf2;
    logic [NE2*DW-1:0] mat_a2, mat_b2, mat_c2;
    logic [DW-1:0]     sa2, sb2, sr2;

    mat_sub_seq #(.DIM(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mat_a(mat_a4), .mat_b(mat_b4),
        .busy(busy4), .done(done4), .mat_c(mat_c4), .err_unexp(err4),
        .sub_a(sa4), .sub_b(sb4), .sub_valid(sv4), .sub_finish(sf4), .sub_result(sr4)
    );

    mat_sub_seq #(.DIM(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mat_a(mat_a2), .mat_b(mat_b2),
        .busy(busy2), .done(done2), .mat_c(mat_c2), .err_unexp(err2),
        .sub_a(sa2), .sub_b(sb2), .sub_valid(sv2), .sub_finish(sf2), .sub_result(sr2)
    );

    // fp_suber stand-ins: L-stage pipelines, not reset, so in-flight work survives a DUT reset.
    logic        pv4 [L];
    logic [63:0] pr4 [L];
    logic        pv2 [L];
    logic [63:0] pr2 [L];

    always @(posedge clk) begin
        pv4[0] <= sv4;
        pr4[0] <= $realtobits($bitstoreal(sa4) - $bitstoreal(sb4));
        pv2[0] <= sv2;
        pr2[0] <= $realtobits($bitstoreal(sa2) - $bitstoreal(sb2));
        for (int i = 1; i < L; i++) begin
            pv4[i] <= pv4[i-1];
            pr4[i] <= pr4[i-1];
            pv2[i] <= pv2[i-1];
            pr2[i] <= pr2[i-1];
        end
    end
    assign sf4 = pv4[L-1];
    assign sr4 = pr4[L-1];
    assign sf2 = pv2[L-1];
    assign sr2 = pr2[L-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference operands as reals; expected C is plain real subtraction.
    real ra [NE4];
    real rb [NE4];

    op_t               opq4 [$];
    logic [NE4*DW-1:0] expc4 [$];
    int                expt4 [$];
    logic [NE2*DW-1:0] expc2 [$];
    int                expt2 [$];

    task automatic rand_ops();
        for (int i = 0; i < NE4; i++) begin
            ra[i] = $itor($urandom_range(0, 4000)) - 2000.0 + $itor($urandom_range(0, 1023)) / 1024.0;
            rb[i] = $itor($urandom_range(0, 4000)) - 2000.0 + $itor($urandom_range(0, 1023)) / 1024.0;
        end
    endtask

    task automatic start4_run(output int t0);
        logic [NE4*DW-1:0] c;
        @(negedge clk);
        check("busy4_before_start", busy4, 0);
        for (int i = 0; i < NE4; i++) begin
            mat_a4[i*DW +: DW] = $realtobits(ra[i]);
            mat_b4[i*DW +: DW] = $realtobits(rb[i]);
            opq4.push_back('{a: $realtobits(ra[i]), b: $realtobits(rb[i])});
            c[i*DW +: DW] = $realtobits(ra[i] - rb[i]);
        end
        t0 = cyc;
        expc4.push_back(c);
        expt4.push_back(t0 + NE4 + L + 1);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("busy4_cycle1", busy4, 1);
    endtask

    task automatic start2_run(output int t0);
        logic [NE2*DW-1:0] c;
        @(negedge clk);
        for (int i = 0; i < NE2; i++) begin
            mat_a2[i*DW +: DW] = $realtobits(ra[i]);
            mat_b2[i*DW +: DW] = $realtobits(rb[i]);
            c[i*DW +: DW] = $realtobits(ra[i] - rb[i]);
        end
        t0 = cyc;
        expc2.push_back(c);
        expt2.push_back(t0 + NE2 + L + 1);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    // Ignored start pulse with scrambled operands on the bus.
    task automatic pulse_ignored4();
        for (int i = 0; i < NE4; i++) begin
            mat_a4[i*DW +: DW] = {$urandom, $urandom};
            mat_b4[i*DW +: DW] = {$urandom, $urandom};
        end
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input bit sel2, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = sel2 ? done2 : done4;
        end
        check(sel2 ? "done2_timeout" : "done4_timeout", seen, 1);
    endtask

    // Monitor: pops expectations whenever the DUT presents an issue or a done.
    op_t               m_op;
    logic [NE4*DW-1:0] m_c4;
    logic [NE2*DW-1:0] m_c2;
    int                m_t;
    int                vcnt4 = 0, vgap4 = 0, vcnt2 = 0, vgap2 = 0;
    bit                vprev4 = 1'b0, vprev2 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sv4) begin
                if (!vprev4 && vcnt4 != 0) vgap4++;
                vcnt4++;
                if (opq4.size() == 0) begin
                    fail("issue4_extra", "sub_valid with no operand expected");
                end else begin
                    m_op = opq4.pop_front();
                    check("sub_a4", sa4, m_op.a);
                    check("sub_b4", sb4, m_op.b);
                end
            end
            vprev4 = sv4;
            if (done4) begin
                if (expc4.size() == 0) begin
                    fail("done4_extra", "done with no run outstanding");
                end else begin
                    m_c4 = expc4.pop_front();
                    m_t  = expt4.pop_front();
                    check("done4_cycle", 64'(cyc), 64'(m_t));
                    check("busy4_at_done", busy4, 1);
                    check("valid4_count", 64'(vcnt4), NE4);
                    check("valid4_gaps", 64'(vgap4), 0);
                    for (int i = 0; i < NE4; i++)
                        check($sformatf("mat_c4[%0d]", i), mat_c4[i*DW +: DW], m_c4[i*DW +: DW]);
                end
                vcnt4 = 0;
                vgap4 = 0;
            end

            if (sv2) begin
                if (!vprev2 && vcnt2 != 0) vgap2++;
                vcnt2++;
            end
            vprev2 = sv2;
            if (done2) begin
                if (expc2.size() == 0) begin
                    fail("done2_extra", "done with no run outstanding");
                end else begin
                    m_c2 = expc2.pop_front();
                    m_t  = expt2.pop_front();
                    check("done2_cycle", 64'(cyc), 64'(m_t));
                    check("valid2_count", 64'(vcnt2), NE2);
                    check("valid2_gaps", 64'(vgap2), 0);
                    for (int i = 0; i < NE2; i++)
                        check($sformatf("mat_c2[%0d]", i), mat_c2[i*DW +: DW], m_c2[i*DW +: DW]);
                end
                vcnt2 = 0;
                vgap2 = 0;
            end
        end
    end

    task automatic check_reset4(input string tag);
        check({tag, "_busy"}, busy4, 0);
        check({tag, "_done"}, done4, 0);
        check({tag, "_sub_valid"}, sv4, 0);
        check({tag, "_sub_a"}, sa4, 0);
        check({tag, "_sub_b"}, sb4, 0);
        check({tag, "_mat_c_nonzero"}, {63'd0, |mat_c4}, 0);
        check({tag, "_err"}, err4, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0;
    logic [63:0] c_el;

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        mat_a4 = '0;
        mat_b4 = '0;
        mat_a2 = '0;
        mat_b2 = '0;
        repeat (5) @(negedge clk);
        check_reset4("rst4");
        check("rst2_busy", busy2, 0);
        check("rst2_err", err2, 0);
        rst_n = 1'b1;

        // Basic: A[i]=i+10, B[i]=i -> every C element is 10.0
        for (int i = 0; i < NE4; i++) begin
            ra[i] = real'(i + 10);
            rb[i] = real'(i);
        end
        start4_run(t0);
        wait_done(1'b0, 60);
        for (int i = 0; i < NE4; i += 5)
            check($sformatf("basic_c[%0d]", i), mat_c4[i*DW +: DW], 64'h4024000000000000);

        // Special values: Inf-Inf is NaN, 1.0-1.0 is +0.0
        rand_ops();
        ra[0] = $bitstoreal(64'h7FF0000000000000);
        rb[0] = $bitstoreal(64'h7FF0000000000000);
        ra[1] = 1.0;
        rb[1] = 1.0;
        start4_run(t0);
        wait_done(1'b0, 60);
        c_el = mat_c4[0 +: DW];
        check("special_c0_is_nan", {63'd0, (&c_el[62:52]) && (|c_el[51:0])}, 1);
        check("special_c1_pos_zero", mat_c4[DW +: DW], 64'h0);

        // Start pulses while busy are ignored
        rand_ops();
        start4_run(t0);
        wait_cyc(t0 + 3);
        pulse_ignored4();
        wait_cyc(t0 + 10);
        pulse_ignored4();
        wait_done(1'b0, 60);
        repeat (NE4 + L + 4) @(negedge clk);
        check("busy_start_idle_after", busy4, 0);

        // Back-to-back: second start in the IDLE cycle right after done
        rand_ops();
        start4_run(t0);
        wait_done(1'b0, 60);
        rand_ops();
        start4_run(t0);
        wait_done(1'b0, 60);
        check("b2b_err", err4, 0);

        // A few more random runs with idle gaps
        for (int r = 0; r < 3; r++) begin
            rand_ops();
            start4_run(t0);
            wait_done(1'b0, 60);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("random_err", err4, 0);

        // Reset mid-operation: one reset cycle at cycle 8
        rand_ops();
        start4_run(t0);
        wait_cyc(t0 + 8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        opq4.delete();
        expc4.delete();
        expt4.delete();
        vcnt4 = 0;
        vgap4 = 0;
        check_reset4("midrst");
        repeat (L + 2) @(negedge clk);
        check("midrst_err_set", err4, 1);
        check("midrst_mat_c_untouched", {63'd0, |mat_c4}, 0);
        check("midrst_idle", busy4, 0);

        // Clean run after the aborted one; the error flag stays sticky
        rand_ops();
        start4_run(t0);
        wait_done(1'b0, 60);
        check("post_rst_err_sticky", err4, 1);

        // DIM=2 build
        for (int r = 0; r < 2; r++) begin
            rand_ops();
            start2_run(t0);
            wait_done(1'b1, 40);
        end
        check("dim2_err", err2, 0);

        repeat (L + 3) @(negedge clk);
        check("pending_runs4", 64'(expc4.size()), 0);
        check("pending_ops4", 64'(opq4.size()), 0);
        check("pending_runs2", 64'(expc2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mat_sub_seq
